// File: rtl/free_list_bank_if.sv
// Free-list bank handshake bundle: reclaim-side enqueue and rename-side dequeue.
//
// Handshake semantics:
//   enq_valid is a push request with no ready signal. The bank accepts it
//   whenever it has room, or when it is full and a dequeue fires in the same
//   cycle. Otherwise the push is dropped and flagged.
//   deq_valid/deq_ready follow strict valid/ready rules. A transfer happens
//   only on a cycle where both are high. deq_PR is stable while deq_valid is
//   high and no transfer has happened. Raising deq_ready while deq_valid is
//   low is a protocol error that the bank records.
interface free_list_bank_if #(
    parameter int LOG_LEN  = 5,
    parameter int LOG_BANK = 2
);
    logic                        enq_valid;
    logic [LOG_LEN-1:0]          enq_PR_upper;
    logic                        deq_valid;
    logic [LOG_LEN+LOG_BANK-1:0] deq_PR;
    logic                        deq_ready;

    // Producer/consumer side (commit reclaim + rename).
    modport master (
        output enq_valid,
        output enq_PR_upper,
        output deq_ready,
        input  deq_valid,
        input  deq_PR
    );

    // The bank itself.
    modport slave (
        input  enq_valid,
        input  enq_PR_upper,
        input  deq_ready,
        output deq_valid,
        output deq_PR
    );
endinterface

// File: rtl/free_list_bank.sv
// One bank of the physical-register free list.
// The bank is a circular FIFO of PR tag upper bits. Every tag it holds has
// BANK_INDEX as its low bits. An occupancy counter tells full apart from empty.
module free_list_bank #(
    parameter int BANK_INDEX                    = 0,
    parameter int FREE_LIST_LENGTH_PER_BANK     = 32,
    parameter int LOG_FREE_LIST_LENGTH_PER_BANK = 5,
    parameter int LOG_FREE_LIST_BANK_COUNT      = 2,
    parameter int AR_COUNT                      = 32,
    parameter int FREE_LIST_LOWER_THRESHOLD     = 8,
    parameter int FREE_LIST_UPPER_THRESHOLD     = 24
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    free_list_bank_if.slave                        fl,
    output logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] count,
    output logic                                   below_lower,
    output logic                                   above_upper,
    output logic                                   overflow_err,
    output logic                                   underflow_err
);
    localparam int PW = LOG_FREE_LIST_LENGTH_PER_BANK;
    localparam int BW = LOG_FREE_LIST_BANK_COUNT;
    // The first AR_COUNT/BANK_COUNT tags of this bank are mapped to
    // architectural registers at reset. Everything above them starts free.
    localparam int RESET_BASE = AR_COUNT / (1 << BW);
    localparam int RESET_FREE = FREE_LIST_LENGTH_PER_BANK - RESET_BASE;

    localparam logic [PW:0]   FULL_COUNT  = (PW+1)'(FREE_LIST_LENGTH_PER_BANK);
    localparam logic [PW:0]   RESET_COUNT = (PW+1)'(RESET_FREE);
    localparam logic [PW-1:0] RESET_TAIL  = PW'(RESET_FREE);
    localparam logic [BW-1:0] BANK_BITS   = BW'(BANK_INDEX);

    logic [PW-1:0] entries_q [FREE_LIST_LENGTH_PER_BANK];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic deq_fire;
    logic enq_fire;

    // A slot freed by a same-cycle dequeue lets a push into a full bank through.
    // An empty bank never bypasses: the pushed tag shows up on the next cycle.
    assign deq_fire = fl.deq_valid & fl.deq_ready;
    assign enq_fire = fl.enq_valid & ((count_q != FULL_COUNT) | deq_fire);

    // Pointer, occupancy and sticky error next-state.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (deq_fire) head_d = head_q + PW'(1);
        if (enq_fire) tail_d = tail_q + PW'(1);
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        if (fl.enq_valid & ~enq_fire)    overflow_d  = 1'b1;
        if (fl.deq_ready & ~fl.deq_valid) underflow_d = 1'b1;
    end

    // Control registers. Reset wins over any same-cycle push or pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q      <= '0;
            tail_q      <= RESET_TAIL;
            count_q     <= RESET_COUNT;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Tag storage: reset preloads the unmapped tags, and each accepted push writes at tail.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < FREE_LIST_LENGTH_PER_BANK; k++) begin
                entries_q[k] <= (k < RESET_FREE) ? PW'(k + RESET_BASE) : '0;
            end
        end else if (enq_fire) begin
            entries_q[tail_q] <= fl.enq_PR_upper;
        end
    end

    // Zero-latency head read and flags derived from the registered count.
    assign fl.deq_valid  = (count_q != '0);
    assign fl.deq_PR     = {entries_q[head_q], BANK_BITS};
    assign count         = count_q;
    assign below_lower   = (count_q < (PW+1)'(FREE_LIST_LOWER_THRESHOLD));
    assign above_upper   = (count_q > (PW+1)'(FREE_LIST_UPPER_THRESHOLD));
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
endmodule

// File: tb/tb_free_list_bank.sv
// Directed bench for free_list_bank instantiated as bank 1.
module tb_free_list_bank;
    localparam int BANK = 1;

    logic       CLK;
    logic       RST;
    logic [5:0] count;
    logic       below_lower;
    logic       above_upper;
    logic       overflow_err;
    logic       underflow_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [4:0] exp_q[$];

    free_list_bank_if #(.LOG_LEN(5), .LOG_BANK(2)) fl_if ();

    free_list_bank #(.BANK_INDEX(BANK)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .fl            (fl_if.slave),
        .count         (count),
        .below_lower   (below_lower),
        .above_upper   (above_upper),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one cycle and land 1ns past the edge, where outputs are settled.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        fl_if.enq_valid    = 1'b0;
        fl_if.enq_PR_upper = '0;
        fl_if.deq_ready    = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_deq_valid"}, 32'(fl_if.deq_valid), 32'd1);
        check({pfx, "_deq_PR"},    32'(fl_if.deq_PR),    32'd33);
        check({pfx, "_count"},     32'(count),           32'd24);
        check({pfx, "_below"},     32'(below_lower),     32'd0);
        check({pfx, "_above"},     32'(above_upper),     32'd0);
        check({pfx, "_ovf"},       32'(overflow_err),    32'd0);
        check({pfx, "_unf"},       32'(underflow_err),   32'd0);
    endtask

    initial begin
        logic [4:0] up;
        RST = 1'b0;
        idle();
        #2;
        do_reset();

        // Reset state.
        check_reset_state("rst");

        // Drain the 24 reset tags: 33, 37, ..., 125.
        fl_if.deq_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            check("drain_valid", 32'(fl_if.deq_valid), 32'd1);
            check("drain_tag",   32'(fl_if.deq_PR),    32'((8 + i) * 4 + BANK));
            tick();
            check("drain_count", 32'(count),       32'(23 - i));
            check("drain_below", 32'(below_lower), 32'((23 - i) < 8));
        end
        fl_if.deq_ready = 1'b0;
        check("empty_valid", 32'(fl_if.deq_valid), 32'd0);
        check("empty_unf",   32'(underflow_err),   32'd0);

        // Push into an empty bank with a pop request: no bypass, underflow flagged.
        fl_if.enq_valid    = 1'b1;
        fl_if.enq_PR_upper = 5'd3;
        fl_if.deq_ready    = 1'b1;
        tick();
        idle();
        check("nobypass_unf",   32'(underflow_err),   32'd1);
        check("nobypass_valid", 32'(fl_if.deq_valid), 32'd1);
        check("nobypass_tag",   32'(fl_if.deq_PR),    32'd13);
        check("nobypass_count", 32'(count),           32'd1);

        // Fill from reset with upper values 0..7, then one push too many.
        do_reset();
        for (int i = 0; i < 24; i++) exp_q.push_back(5'(8 + i));
        for (int i = 0; i < 8; i++) begin
            fl_if.enq_valid    = 1'b1;
            fl_if.enq_PR_upper = 5'(i);
            exp_q.push_back(5'(i));
            tick();
            check("fill_count", 32'(count),       32'(25 + i));
            check("fill_above", 32'(above_upper), 32'd1);
        end
        fl_if.enq_PR_upper = 5'd9;
        tick();
        idle();
        check("ovf_count", 32'(count),        32'd32);
        check("ovf_flag",  32'(overflow_err), 32'd1);
        check("ovf_head",  32'(fl_if.deq_PR), 32'd33);

        // Full bank: push 5 and pop at once; the freed slot takes the write.
        fl_if.enq_valid    = 1'b1;
        fl_if.enq_PR_upper = 5'd5;
        fl_if.deq_ready    = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(5'd5);
        tick();
        idle();
        check("full_swap_count", 32'(count),        32'd32);
        check("full_swap_ovf",   32'(overflow_err), 32'd1);

        // Drain all 32 entries in FIFO order; tag 5 is the last one out.
        fl_if.deq_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            up = exp_q.pop_front();
            check("wrap_valid", 32'(fl_if.deq_valid), 32'd1);
            check("wrap_tag",   32'(fl_if.deq_PR),    32'({up, 2'(BANK)}));
            if (i == 31) check("wrap_last", 32'(fl_if.deq_PR), 32'd21);
            tick();
            check("wrap_count", 32'(count), 32'(31 - i));
        end
        // One extra pop on empty raises the sticky underflow.
        tick();
        fl_if.deq_ready = 1'b0;
        check("wrap_unf", 32'(underflow_err), 32'd1);

        // Mid-stream reset with a push and a pop in the same cycle.
        fl_if.enq_valid    = 1'b1;
        fl_if.enq_PR_upper = 5'd2;
        tick();
        check("mid_count", 32'(count), 32'd1);
        fl_if.deq_ready = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        idle();
        check_reset_state("mid_rst");
        fl_if.deq_ready = 1'b1;
        tick();
        idle();
        check("mid_rst_next_tag", 32'(fl_if.deq_PR), 32'd37);
        check("mid_rst_count",    32'(count),        32'd23);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/free_list_bank.md
Name: free_list_bank

Overview:
- One bank of the physical-register free list.
- The writer side is the commit/reclaim path, which returns freed PRs. The reader side is rename, which allocates new destination PRs.
- Implements a circular FIFO of PR tags whose low LOG_FREE_LIST_BANK_COUNT bits equal BANK_INDEX. FREE_LIST_BANK_COUNT instances form the full free list.
- Exports fill-level threshold flags so rename can steer allocation toward fuller banks.

Parameters:
- BANK_INDEX, 0, this bank's id; supplies the low bits of every PR tag in the bank.
- FREE_LIST_LENGTH_PER_BANK, 32, FIFO depth (PR_COUNT / FREE_LIST_BANK_COUNT).
- LOG_FREE_LIST_LENGTH_PER_BANK, 5, pointer/index width.
- LOG_FREE_LIST_BANK_COUNT, 2, bank-select bit count.
- AR_COUNT, 32, architectural regs; tags below this are mapped at reset and are not free.
- FREE_LIST_LOWER_THRESHOLD, 8, low-water mark.
- FREE_LIST_UPPER_THRESHOLD, 24, high-water mark.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- enq_valid  in  1  freed PR returned this cycle.
- enq_PR_upper  in  5  upper bits of the returned tag; tag = {enq_PR_upper, BANK_INDEX}.
- deq_valid  out  1  bank non-empty; head tag available.
- deq_PR  out  7  head tag = {head entry, BANK_INDEX}.
- deq_ready  in  1  rename consumes head this cycle.
- count  out  6  current occupancy, 0..32.
- below_lower  out  1  count < FREE_LIST_LOWER_THRESHOLD.
- above_upper  out  1  count > FREE_LIST_UPPER_THRESHOLD.
- overflow_err  out  1  sticky; set when an enq is dropped.
- underflow_err  out  1  sticky; set when deq_ready is asserted while deq_valid is low.

Behaviour:
- Reset (synchronous, RST high at posedge):
  - entries[k] = k + AR_COUNT/FREE_LIST_BANK_COUNT for k = 0..23, i.e. upper values 8..31. With BANK_INDEX=0 the tags are 32, 36, ..., 124.
  - head = 0, tail = 24, count = 24.
  - overflow_err = underflow_err = 0.
  - Outputs after reset: deq_valid=1, deq_PR={5'd8, BANK_INDEX}, below_lower=0, above_upper=0.
- Storage:
  - 32 x 5-bit array; head and tail are 5-bit pointers that wrap mod 32.
  - count is a 6-bit register and disambiguates full from empty.
- Dequeue:
  - deq_valid = (count != 0).
  - deq_PR is driven combinationally from entries[head], so there is zero-cycle read latency.
  - A dequeue happens when deq_valid & deq_ready. The following cycle, head increments (wrapping 31->0) and count decrements.
- Enqueue:
  - An enqueue happens when enq_valid and either count < 32, or count == 32 with a dequeue in the same cycle.
  - On enqueue: entries[tail] <= enq_PR_upper, tail increments (wrapping), count increments.
  - enq_valid with count == 32 and no dequeue: the write is dropped, state is unchanged, and overflow_err is set to 1.
- Simultaneous enqueue and dequeue:
  - count is unchanged; both pointers advance.
  - When full, the freed slot accepts the write.
  - When empty (count == 0), there is no bypass. The enqueue is accepted, the dequeue does not occur (deq_valid=0), and the enqueued tag appears on deq_PR the next cycle.
- underflow_err: deq_ready & ~deq_valid sets it; state is unchanged.
- Both error flags clear only on RST.
- below_lower and above_upper are combinational from the count register, so they reflect the post-update count one cycle after the event.
- Reset mid-operation: RST has priority over any enq or deq in the same cycle. All pointers, contents and flags return to their reset values.

Test Plan:
- Reset, BANK_INDEX=1 -> deq_valid=1, deq_PR=7'd33, count=24, below_lower=0, above_upper=0, both error flags 0.
- Hold deq_ready for 24 cycles -> tags 33, 37, ..., 125 in order. Then deq_valid=0 and count=0. below_lower rises once count reaches 7.
- Empty bank; enq_valid with enq_PR_upper=3 and deq_ready=1 in the same cycle -> no dequeue, underflow_err=1. Next cycle deq_valid=1, deq_PR=7'd13, count=1.
- From reset, enqueue upper values 0..7 over 8 cycles -> count=32, above_upper=1. A 9th enqueue with no dequeue -> dropped, count=32, overflow_err=1.
- Full bank; enq (upper=5) and deq in the same cycle -> count stays 32. Head and tail wrap correctly, and the tag 5 is the last one out after 31 further dequeues.
- Mid-stream: RST asserted together with enq_valid and deq_ready -> next cycle state equals the reset state exactly (count=24, deq_PR={8, BANK_INDEX}).
